// File: rtl/bit_cldiv.sv
// Iterative carry-less (GF(2) polynomial) divider: one quotient bit per cycle,
// returning either the quotient (cldiv) or the remainder (clrem).
module bit_cldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            op_cldiv,
  input  logic            op_clrem,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   k_q, k_d;
  logic              zero_q, zero_d;
  logic              op_div_q, op_div_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [CntW-1:0]   msb;
  logic [XLEN-1:0]   t;
  logic              hit;

  // Divisor degree; highest set bit wins.
  always_comb begin
    msb = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (rdata2[i]) msb = CntW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    zero_d   = zero_q;
    op_div_d = op_div_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    ready    = 1'b0;

    // rem has degree < k here, so its top bit is always zero and nothing is lost.
    t   = {rem_q[XLEN-2:0], dvd_q[cnt_q]};
    hit = !zero_q && t[k_q];

    case (state_q)
      StIdle: begin
        if (enable && (op_cldiv || op_clrem)) begin
          dvd_d    = rdata1;
          dvs_d    = rdata2;
          op_div_d = op_cldiv;
          k_d      = msb;
          zero_d   = (rdata2 == '0);
          rem_d    = '0;
          quot_d   = '0;
          cnt_d    = CntW'(XLEN - 1);
          result_d = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        rem_d         = hit ? (t ^ dvs_q) : t;
        quot_d[cnt_q] = hit;
        if (cnt_q == '0) begin
          result_d = op_div_q ? quot_d : rem_d;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // Encoding 3 behaves as DONE.
        ready   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= CntW'(XLEN - 1);
      k_q      <= '0;
      zero_q   <= 1'b0;
      op_div_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      zero_q   <= zero_d;
      op_div_q <= op_div_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_bit_cldiv.sv
// Self-checking bench for bit_cldiv: directed vector table, protocol corners,
// mid-operation reset and randomized operands against a long-division model.
module tb_bit_cldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        op_cldiv;
  logic        op_clrem;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  bit_cldiv #(.XLEN(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .op_cldiv (op_cldiv),
    .op_clrem (op_clrem),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .result   (result),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic int degree(input logic [31:0] p);
    int d = -1;
    for (int i = 0; i < 32; i++) if (p[i]) d = i;
    return d;
  endfunction

  // Textbook polynomial long division over GF(2).
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    int db = degree(b);
    q = '0;
    r = a;
    if (db < 0) return;
    for (int d = 31; d >= db; d--) begin
      if (r[d]) begin
        r = r ^ (b << (d - db));
        q[d - db] = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++) if (x[i]) p = p ^ ({32'd0, y} << i);
    return p;
  endfunction

  // Enters at a negedge in IDLE, returns at the negedge of the IDLE cycle after DONE,
  // so a call made straight after another exercises back-to-back acceptance.
  task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, output logic [31:0] res);
    int  lat    = 0;
    int  pulses = 0;
    bit  seen   = 0;
    bit  clean  = 1;
    bit  r;
    enable   = 1'b1;
    op_cldiv = div;
    op_clrem = !div;
    rdata1   = a;
    rdata2   = b;
    res      = 'x;
    @(posedge clock);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clock);
      if (ready) begin
        seen   = 1;
        pulses++;
        lat    = n;
        res    = result;
        enable = 1'b0;
      end else begin
        if (result !== 32'd0) clean = 0;
        if (toggle) begin
          r        = 1'($urandom);
          enable   = 1'($urandom);
          op_cldiv = r;
          op_clrem = !r;
          rdata1   = $urandom;
          rdata2   = $urandom;
        end else begin
          enable = 1'b0;
        end
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    @(negedge clock);
    if (ready) pulses++;
    check("latency", 32'(lat), 32'd33);
    check("pulse_count", 32'(pulses), 32'd1);
    check("busy_result_zero", 32'(clean), 32'd1);
    check("result_hold", result, res);
  endtask

  vec_t        vecs[$];
  logic [31:0] res, q, r, qd, rd;
  int          rst_pulses;

  initial begin
    vecs = '{
      '{1'b1, 32'h0000000F, 32'h00000003, 32'h00000005},
      '{1'b0, 32'h0000000F, 32'h00000003, 32'h00000000},
      '{1'b1, 32'h00000013, 32'h00000003, 32'h0000000E},
      '{1'b0, 32'h00000013, 32'h00000003, 32'h00000001},
      '{1'b1, 32'hDEADBEEF, 32'h00000000, 32'h00000000},
      '{1'b0, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF},
      '{1'b1, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF},
      '{1'b0, 32'hDEADBEEF, 32'h00000001, 32'h00000000},
      '{1'b1, 32'h00000005, 32'h00000100, 32'h00000000},
      '{1'b0, 32'h00000005, 32'h00000100, 32'h00000005},
      '{1'b1, 32'h80000000, 32'h80000001, 32'h00000001},
      '{1'b0, 32'h80000000, 32'h80000001, 32'h00000001},
      '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
      '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000}
    };

    reset    = 1'b1;
    enable   = 1'b0;
    op_cldiv = 1'b0;
    op_clrem = 1'b0;
    rdata1   = '0;
    rdata2   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    // Directed table, issued back-to-back; odd entries toggle inputs while busy.
    foreach (vecs[i]) begin
      run_op(vecs[i].div, vecs[i].a, vecs[i].b, 1'(i % 2), res);
      check($sformatf("vec%0d", i), res, vecs[i].exp);
    end

    // Reset while BUSY with counter at 16 aborts without a ready pulse.
    enable   = 1'b1;
    op_cldiv = 1'b1;
    op_clrem = 1'b0;
    rdata1   = 32'h00000013;
    rdata2   = 32'h00000003;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_result", result, 32'd0);
    reset      = 1'b0;
    rst_pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (ready) rst_pulses++;
    end
    check("abort_no_pulse", 32'(rst_pulses), 32'd0);
    run_op(1'b1, 32'h00000013, 32'h00000003, 1'b0, res);
    check("after_abort", res, 32'h0000000E);

    // Randomized pairs: model comparison plus the division identity.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) b = '0;
      ref_div(a, b, q, r);
      run_op(1'b1, a, b, 1'(i % 3 == 0), qd);
      run_op(1'b0, a, b, 1'b0, rd);
      check($sformatf("rand%0d_quot", i), qd, q);
      check($sformatf("rand%0d_rem", i), rd, r);
      if (b != 0) begin
        check($sformatf("rand%0d_identity", i), 32'(clmul(qd, b) ^ {32'd0, rd}), a);
        check($sformatf("rand%0d_rem_deg", i), 32'(degree(rd) < degree(b)), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
